bitmap_ram_writer: RTL and testbench
====================================

Name: bitmap_ram_writer

Overview:
- Writable 1-bpp bitmap store: the write-side counterpart of the ROM bitmap reader.
- Accepts a packed byte stream over a valid/ready handshake, MSB = leftmost pixel, raster order.
- Unpacks each byte into a WIDTH x HEIGHT single-bit RAM.
- Exposes the same registered (x, y) -> pixel read port the LCD scan logic already uses, so it drops in for the ROM when the image must be loaded at run time (e.g. from UART).

Parameters:
- ADDR_WIDTH, 10, width of the x and y coordinate inputs.
- WIDTH, 256, bitmap width in pixels; WIDTH*HEIGHT must be a multiple of 8.
- HEIGHT, 128, bitmap height in pixels.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- in_data  in  8  packed pixel byte; bit 7 = first (leftmost) pixel.
- in_valid  in  1  in_data is valid.
- in_sof  in  1  start of frame; qualifies the byte offered with in_valid.
- in_ready  out  1  byte is accepted on a cycle where in_valid && in_ready.
- busy  out  1  unpacker is currently writing pixels.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written.
- x  in  ADDR_WIDTH  read column.
- y  in  ADDR_WIDTH  read row.
- pixel  out  1  registered read data.

Behaviour:
- Constants:
  - NPIX = WIDTH*HEIGHT.
  - Write address waddr is wide enough for NPIX-1.
  - Bit counter cnt is 3 bits.
- Reset (resetn low at a clk edge):
  - state = IDLE, waddr = 0, cnt = 0.
  - in_ready = 1 (combinational from state), busy = 0, frame_done = 0, pixel = 0.
  - RAM contents are NOT cleared.
  - Reset mid-byte abandons the remaining bits; pixels already written stay.
- State IDLE:
  - in_ready = 1.
  - On accept: latch in_data into shift register sh, cnt = 0, go to SHIFT.
  - If in_sof is set on the accepted byte, waddr = 0 before any write.
- State SHIFT (busy = 1):
  - Each cycle: write sh[7-cnt] to RAM[waddr], then cnt += 1.
  - waddr increments, wrapping from NPIX-1 to 0.
  - in_ready = 1 only when cnt == 7, which allows back-to-back bytes.
  - On cnt == 7 with accept: reload sh, cnt = 0, stay in SHIFT. Sustained rate is 8 clk per byte with no bubble.
  - On cnt == 7 without accept: go to IDLE.
- in_sof on a byte accepted at cnt == 7:
  - The current byte's bit 0 is still written at the current waddr.
  - The next write goes to address 0; the partial frame is dropped.
  - frame_done is not pulsed for a dropped frame.
- frame_done:
  - Registered; high for exactly 1 cycle, the cycle after the write to waddr == NPIX-1.
  - Not pulsed when wrap is caused by in_sof.
- Read port:
  - raddr = y*WIDTH + x, computed at full product width (no truncation).
  - pixel <= RAM[raddr] on every clk, so latency is 1 cycle.
  - If x >= WIDTH or y >= HEIGHT, pixel <= 0.
  - Simultaneous read and write of the same address is read-first: pixel returns the old value.
- in_data and in_sof are ignored unless the handshake completes.
- Holding in_valid high while in_ready is low must not lose or duplicate a byte.

Decomposition:
- Package bitmap_pkg holds:
  - the NPIX derivation;
  - the state encoding (IDLE, SHIFT);
  - the raddr width function shared with the ROM reader.
- Sub-module bitmap_ram: 1-bit, NPIX-deep simple dual-port RAM.
  - Write port: we, waddr, wdata.
  - Registered read-first read port.
  - Range gating lives there, so the LCD path sees identical timing for ROM and RAM variants.
- The FSM, shift register and counters live in bitmap_ram_writer.

Test Plan:
- Reset then idle:
  - Stimulus: resetn low 2 cycles, then release.
  - Required: in_ready = 1, busy = 0, frame_done = 0, pixel = 0.
- Single byte:
  - Stimulus: 0xA5 with in_sof.
  - Required: RAM[0..7] = 1,0,1,0,0,1,0,1; in_ready low for 7 cycles.
  - Required: reading (x=0..7, y=0) returns the same bits 1 cycle after each address.
- Full frame, back-to-back:
  - Stimulus: WIDTH=16, HEIGHT=2, 4 bytes 0xFF,0x00,0x0F,0xF0 with in_valid held high.
  - Required: the 4 accepts are exactly 8 cycles apart.
  - Required: frame_done pulses once, 1 cycle after the 32nd write.
  - Required: (x=4,y=1) reads 1; (x=3,y=1) reads 0.
- Abort with in_sof:
  - Stimulus: 2 bytes 0xFF, then 0x00 with in_sof.
  - Required: RAM[0..7] = 0, RAM[8..15] = 1, no frame_done.
- Out of range and read/write collision:
  - Stimulus: read x=WIDTH.
  - Required: pixel = 0.
  - Stimulus: read the address being written in the same cycle.
  - Required: old value, with the new value on the next read.
- Reset mid-byte:
  - Stimulus: assert resetn low at cnt = 3.
  - Required: bits 0..2 stay written, the next byte after reset is written at waddr 0, no spurious frame_done.

Source files
------------

// File: rtl/bitmap_pkg.sv
// -----------------------------------------------------------------------------
// bitmap_pkg
//
// Shared definitions for the 1-bpp bitmap store (ROM reader and RAM writer).
//   - wr_state_e : writer FSM encoding (IDLE, SHIFT)
//   - npix_f     : pixel count of a WIDTH x HEIGHT bitmap
//   - waddr_w_f  : width of a linear pixel address able to hold NPIX-1
//   - raddr_w_f  : width of the (y*WIDTH + x) read address at full product
//                  width, so out-of-range coordinates never alias in range
// -----------------------------------------------------------------------------
package bitmap_pkg;

  // Pixels per packed input byte.
  localparam int unsigned BYTE_BITS = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } wr_state_e;

  function automatic int npix_f(input int w, input int h);
    return w * h;
  endfunction

  function automatic int waddr_w_f(input int npix);
    return (npix > 1) ? $clog2(npix) : 1;
  endfunction

  // y < 2^aw and x < 2^aw, so y*w + x < 2^(aw + clog2(w) + 1).
  function automatic int raddr_w_f(input int aw, input int w);
    return aw + $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/bitmap_ram.sv
// -----------------------------------------------------------------------------
// bitmap_ram
//
// 1-bit, NPIX-deep simple dual-port RAM with the same registered (x, y) read
// port as the ROM bitmap reader, so the LCD scan path sees identical timing
// for either variant.
//
// Ports:
//   clk     in   system clock, rising edge
//   resetn  in   synchronous active-low reset (clears only the read register)
//   we      in   write enable
//   waddr   in   linear write address
//   wdata   in   write data bit
//   x       in   read column
//   y       in   read row
//   pixel   out  registered read data, 1-cycle latency, 0 when out of range
//
// The read is read-first: a read and write of the same address on the same
// edge returns the previous contents.
// -----------------------------------------------------------------------------
module bitmap_ram
  import bitmap_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int WIDTH      = 256,
  parameter int HEIGHT     = 128
) (
  input  logic                                        clk,
  input  logic                                        resetn,
  input  logic                                        we,
  input  logic [waddr_w_f(npix_f(WIDTH, HEIGHT))-1:0] waddr,
  input  logic                                        wdata,
  input  logic [ADDR_WIDTH-1:0]                       x,
  input  logic [ADDR_WIDTH-1:0]                       y,
  output logic                                        pixel
);

  localparam int NPIX = npix_f(WIDTH, HEIGHT);
  localparam int WA   = waddr_w_f(NPIX);
  localparam int RW   = raddr_w_f(ADDR_WIDTH, WIDTH);

  localparam logic [31:0] WIDTH_U  = 32'(WIDTH);
  localparam logic [31:0] HEIGHT_U = 32'(HEIGHT);
  localparam logic [RW-1:0] NPIX_R = RW'(NPIX);

  logic mem [NPIX];

  logic [RW-1:0] raddr;
  logic [31:0]   x_ext;
  logic [31:0]   y_ext;
  logic          in_range;
  logic          pixel_d;
  logic          pixel_q;

  // Write port: the array is never reset, so a reset leaves the image intact.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    x_ext = 32'(x);
    y_ext = 32'(y);
    raddr = (RW'(y) * RW'(WIDTH)) + RW'(x);
    // The raddr bound is implied by the coordinate checks; keeping it makes
    // the gate robust should the coordinate checks ever be relaxed.
    in_range = (x_ext < WIDTH_U) && (y_ext < HEIGHT_U) && (raddr < NPIX_R);
    pixel_d  = 1'b0;
    if (in_range) begin
      pixel_d = mem[raddr[WA-1:0]];
    end
  end

  // Non-blocking update against the write above gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pixel_q <= 1'b0;
    end else begin
      pixel_q <= pixel_d;
    end
  end

  assign pixel = pixel_q;

endmodule

// File: rtl/bitmap_ram_writer.sv
// -----------------------------------------------------------------------------
// bitmap_ram_writer
//
// Run-time loadable 1-bpp bitmap. A packed byte stream (bit 7 = leftmost
// pixel, raster order) arrives over valid/ready and is unpacked one pixel per
// clock into a WIDTH x HEIGHT bit RAM. The read side is the registered
// (x, y) -> pixel port used by the LCD scan logic.
//
// Ports:
//   clk         in   system clock, rising edge
//   resetn      in   synchronous active-low reset
//   in_data     in   packed pixel byte
//   in_valid    in   in_data valid
//   in_sof      in   start of frame, qualifies the offered byte
//   in_ready    out  byte accepted when in_valid && in_ready
//   busy        out  unpacker is writing pixels
//   frame_done  out  1-cycle pulse after the write of the last frame pixel
//   x, y        in   read coordinates
//   pixel       out  registered read data
//
// Throughput is 8 clocks per byte; in_ready rises on the last bit of the
// current byte so the next byte loads without a bubble.
// -----------------------------------------------------------------------------
module bitmap_ram_writer
  import bitmap_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int WIDTH      = 256,
  parameter int HEIGHT     = 128
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  frame_done,
  input  logic [ADDR_WIDTH-1:0] x,
  input  logic [ADDR_WIDTH-1:0] y,
  output logic                  pixel
);

  localparam int NPIX = npix_f(WIDTH, HEIGHT);
  localparam int WA   = waddr_w_f(NPIX);

  localparam logic [WA-1:0] LAST_ADDR = WA'(NPIX - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(BYTE_BITS - 1);

  wr_state_e     state_q, state_d;
  logic [WA-1:0] waddr_q, waddr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          frame_done_q, frame_done_d;

  logic          accept;
  logic          we;
  logic          wdata;

  // in_ready is a pure function of state so a stalled producer holding
  // in_valid high can never be accepted twice for the same byte.
  always_comb begin
    in_ready = 1'b1;
    if (state_q == SHIFT) begin
      in_ready = (cnt_q == LAST_BIT);
    end
  end

  assign busy   = (state_q == SHIFT);
  assign accept = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    frame_done_d = 1'b0;
    // Writes are suppressed on a reset edge so an abandoned byte does not
    // leave one extra bit behind.
    we           = 1'b0;
    // 7 - cnt as a 3-bit value is simply ~cnt: MSB first.
    wdata        = sh_q[~cnt_q];

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sh_d    = in_data;
          cnt_d   = 3'd0;
          state_d = SHIFT;
          if (in_sof) begin
            waddr_d = '0;
          end
        end
      end

      SHIFT: begin
        we    = resetn;
        cnt_d = cnt_q + 3'd1;
        if (waddr_q == LAST_ADDR) begin
          waddr_d      = '0;
          frame_done_d = 1'b1;
        end else begin
          waddr_d = waddr_q + 1'b1;
        end

        if (cnt_q == LAST_BIT) begin
          if (accept) begin
            sh_d  = in_data;
            cnt_d = 3'd0;
            // The current bit 0 is still written above; only the next
            // write restarts at address 0, dropping the partial frame.
            if (in_sof) begin
              waddr_d = '0;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      waddr_q      <= '0;
      cnt_q        <= 3'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Shift register is pure data: only meaningful after a load.
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  assign frame_done = frame_done_q;

  bitmap_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT)
  ) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .we     (we),
    .waddr  (waddr_q),
    .wdata  (wdata),
    .x      (x),
    .y      (y),
    .pixel  (pixel)
  );

endmodule

// File: tb/tb_bitmap_ram_writer.sv
module tb_bitmap_ram_writer;

  localparam int AW = 10;
  localparam int W  = 16;
  localparam int H  = 2;

  logic          clk;
  logic          resetn;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_sof;
  logic          in_ready;
  logic          busy;
  logic          frame_done;
  logic [AW-1:0] x;
  logic [AW-1:0] y;
  logic          pixel;

  int n_vec = 0;
  int n_err = 0;

  bitmap_ram_writer #(
    .ADDR_WIDTH (AW),
    .WIDTH      (W),
    .HEIGHT     (H)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_ready   (in_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .x          (x),
    .y          (y),
    .pixel      (pixel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read linear address a: present coordinates, one edge later pixel is valid.
  task automatic rd(input string tag, input int a, input logic exp);
    x = AW'(a % W);
    y = AW'(a / W);
    tick();
    chk(tag, {31'd0, pixel}, {31'd0, exp});
  endtask

  // Offer n bytes with in_valid held high; record the cycle of each accept
  // and every frame_done pulse. Bounded by a fixed cycle budget.
  task automatic stream(input logic [7:0] b [4], input logic s [4], input int n,
                        output int acc_c [4], output int fd_n, output int fd_c);
    int bi;
    bi   = 0;
    fd_n = 0;
    fd_c = -1;
    for (int k = 0; k < 4; k++) acc_c[k] = -1;
    in_valid = 1'b1;
    in_data  = b[0];
    in_sof   = s[0];
    for (int c = 0; c < 8 * n + 10; c++) begin
      logic acc;
      acc = in_valid && in_ready;
      tick();
      if (frame_done) begin
        fd_n++;
        fd_c = c;
      end
      if (acc) begin
        acc_c[bi] = c;
        bi++;
        if (bi < n) begin
          in_data = b[bi];
          in_sof  = s[bi];
        end else begin
          in_valid = 1'b0;
          in_sof   = 1'b0;
        end
      end
    end
    chk("accept_count", 32'(bi), 32'(n));
  endtask

  initial begin
    int         acc_c [4];
    int         fd_n;
    int         fd_c;
    logic [7:0] a5_bits;

    resetn   = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    x        = '0;
    y        = '0;

    // Reset then idle
    tick();
    tick();
    resetn = 1'b1;
    chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
    chk("rst_busy",       {31'd0, busy},       32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_pixel",      {31'd0, pixel},      32'd0);

    // Single byte 0xA5 with sof: ready low for cnt 0..6, high at cnt 7
    in_data  = 8'hA5;
    in_sof   = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a5_ready_cnt%0d", i), {31'd0, in_ready}, (i == 7) ? 32'd1 : 32'd0);
      chk($sformatf("a5_busy_cnt%0d", i),  {31'd0, busy},     32'd1);
      tick();
    end
    chk("a5_idle_busy", {31'd0, busy}, 32'd0);
    // 0xA5 = 1010_0101, leftmost first
    a5_bits = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      rd($sformatf("a5_px%0d", i), i, a5_bits[7 - i]);
    end

    // Full 16x2 frame, back to back
    stream('{8'hFF, 8'h00, 8'h0F, 8'hF0}, '{1'b1, 1'b0, 1'b0, 1'b0}, 4, acc_c, fd_n, fd_c);
    chk("ff_gap01", 32'(acc_c[1] - acc_c[0]), 32'd8);
    chk("ff_gap12", 32'(acc_c[2] - acc_c[1]), 32'd8);
    chk("ff_gap23", 32'(acc_c[3] - acc_c[2]), 32'd8);
    chk("ff_fd_count", 32'(fd_n), 32'd1);
    chk("ff_fd_cycle", 32'(fd_c), 32'(acc_c[3] + 8));
    rd("ff_x4y1", 20, 1'b1);
    rd("ff_x3y1", 19, 1'b0);
    rd("ff_x0y0", 0,  1'b1);
    rd("ff_x8y0", 8,  1'b0);
    rd("ff_x15y1", 31, 1'b0);

    // Abort: FF(sof), FF, 00(sof) -> 0..7 = 0, 8..15 = 1, no frame_done
    stream('{8'hFF, 8'hFF, 8'h00, 8'h00}, '{1'b1, 1'b0, 1'b1, 1'b0}, 3, acc_c, fd_n, fd_c);
    chk("ab_fd_count", 32'(fd_n), 32'd0);
    rd("ab_px0",  0,  1'b0);
    rd("ab_px7",  7,  1'b0);
    rd("ab_px8",  8,  1'b1);
    rd("ab_px15", 15, 1'b1);

    // Out of range reads (address 20 holds 1, so aliasing would show)
    rd("oor_pre", 8, 1'b1);
    x = AW'(W);
    y = '0;
    tick();
    chk("oor_x16", {31'd0, pixel}, 32'd0);
    x = AW'(W + 4);
    tick();
    chk("oor_x20", {31'd0, pixel}, 32'd0);
    x = '0;
    y = AW'(H);
    tick();
    chk("oor_y2", {31'd0, pixel}, 32'd0);

    // Read/write collision on address 3 (old 0, new 1)
    x        = AW'(3);
    y        = '0;
    in_data  = 8'hFF;
    in_sof   = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("col_old", {31'd0, pixel}, 32'd0);
    tick();
    chk("col_new", {31'd0, pixel}, 32'd1);
    tick();
    tick();
    tick();
    chk("col_idle", {31'd0, busy}, 32'd0);

    // Reset mid-byte: 0x00 with sof, reset while cnt = 3
    in_data  = 8'h00;
    in_sof   = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    tick();
    tick();
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("mr_busy",       {31'd0, busy},       32'd0);
    chk("mr_in_ready",   {31'd0, in_ready},   32'd1);
    chk("mr_frame_done", {31'd0, frame_done}, 32'd0);
    rd("mr_px0", 0, 1'b0);
    rd("mr_px2", 2, 1'b0);
    rd("mr_px3", 3, 1'b1);
    rd("mr_px7", 7, 1'b1);
    // Next byte without sof must land at address 0
    stream('{8'hFF, 8'h00, 8'h00, 8'h00}, '{1'b0, 1'b0, 1'b0, 1'b0}, 1, acc_c, fd_n, fd_c);
    chk("mr_fd_count", 32'(fd_n), 32'd0);
    rd("mr_new_px0", 0, 1'b1);
    rd("mr_new_px1", 1, 1'b1);
    rd("mr_new_px8", 8, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
